dmem_wait: RTL and testbench

DMEM_WAIT -- requirements
Module: dmem_wait

---
 rtl/dmem_wait_pkg.sv | 35 +++
 rtl/dmem_byte_array.sv | 38 +++
 rtl/dmem_wait.sv | 226 ++++++++++++++++++++++
 tb/tb_dmem_wait.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_wait_pkg.sv
// Shared definitions for the wait-state data memory: access size codes,
// controller states, the captured request record and a size helper.
package dmem_wait_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Number of bytes touched by an access; the illegal code is treated as a
  // word so the range check stays well defined (it faults anyway).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressable storage organised as 32-bit rows with four byte-lane
// write enables. Lane 0 is the lowest byte address and sits in bits 31:24
// (big-endian). Write and read are both synchronous; contents are not reset.
module dmem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned WA          = 6
) (
  input  logic          clk,
  input  logic [3:0]    wr_be,
  input  logic          rd_en,
  input  logic [WA-1:0] word_addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data
);

  localparam int unsigned NWORDS = DEPTH_BYTES / 4;

  logic [0:3][7:0] mem [NWORDS];
  logic [0:3][7:0] wr_lanes;

  // Reinterpret the right-justified write bus as four big-endian lanes.
  always_comb begin
    wr_lanes = wr_data;
  end

  // Per-lane write and registered row read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (wr_be[i]) begin
        mem[word_addr][2'(i)] <= wr_lanes[2'(i)];
      end
    end
    if (rd_en) begin
      rd_data <= mem[word_addr];
    end
  end

endmodule

// File: rtl/dmem_wait.sv
// Data memory with a configurable number of wait states. One request is in
// flight at a time: IDLE accepts, WAIT burns WAIT_CYCLES edges, RESP emits a
// one-cycle response. Stores commit and loads read on the edge entering RESP.
module dmem_wait
  import dmem_wait_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_BYTES);
  localparam int unsigned WA        = (AW > 2) ? AW - 2 : 1;
  localparam logic [2:0]  WAIT_LAST = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [2:0]    wait_cnt;
  logic          ready_q;
  req_t          cap_q;
  req_t          live;
  req_t          cur;
  logic          accept;
  logic          enter_resp;
  logic          fault;
  logic [32:0]   last_byte;
  logic [3:0]    mem_be;
  logic          mem_re;
  logic [WA-1:0] word_addr;
  logic [31:0]   wr_word;
  logic [31:0]   rd_word;
  logic          err_q;
  logic [31:0]   hold_q;
  logic [31:0]   fmt;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  // The live request fields, bundled for capture.
  always_comb begin
    live.write = req_write;
    live.size  = req_size;
    live.sext  = req_signed;
    live.addr  = req_addr;
    live.wdata = req_wdata;
  end

  // With zero wait states the memory access happens on the accepting edge,
  // before the capture register is loaded, so IDLE looks at the live fields.
  // The result is identical to evaluating the captured copy.
  always_comb begin
    cur = (state == IDLE) ? live : cap_q;
  end

  // Fault detection: illegal size, misalignment, or running past the end.
  always_comb begin
    last_byte = {1'b0, cur.addr} + {30'b0, size_bytes(cur.size)} - 33'd1;
    fault = (cur.size == 2'b11)
          | ((cur.size == SZ_HALF) & cur.addr[0])
          | ((cur.size == SZ_WORD) & (cur.addr[1:0] != 2'b00))
          | (last_byte >= 33'(DEPTH_BYTES));
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ready_q;
        if (req_valid && ready_q) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait-state counter, cleared whenever not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == WAIT && wait_cnt != WAIT_LAST) begin
      wait_cnt <= wait_cnt + 3'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Ready is held low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (accept) begin
      cap_q <= live;
    end
  end

  // Memory control: lane enables and replicated store data for the access.
  always_comb begin
    mem_be    = '0;
    mem_re    = 1'b0;
    wr_word   = cur.wdata;
    word_addr = WA'(cur.addr >> 2);
    case (cur.size)
      SZ_BYTE: wr_word = {4{cur.wdata[7:0]}};
      SZ_HALF: wr_word = {2{cur.wdata[15:0]}};
      default: wr_word = cur.wdata;
    endcase
    if (enter_resp && !fault) begin
      if (cur.write) begin
        case (cur.size)
          SZ_BYTE: mem_be = 4'b0001 << cur.addr[1:0];
          SZ_HALF: mem_be = 4'b0011 << cur.addr[1:0];
          default: mem_be = 4'b1111;
        endcase
      end else begin
        mem_re = 1'b1;
      end
    end
  end

  dmem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .WA          (WA)
  ) u_mem (
    .clk       (clk),
    .wr_be     (mem_be),
    .rd_en     (mem_re),
    .word_addr (word_addr),
    .wr_data   (wr_word),
    .rd_data   (rd_word)
  );

  // Error flag is fixed when the access is performed and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (enter_resp) begin
      err_q <= fault;
    end
  end

  // Load result alignment and extension from the registered memory row.
  always_comb begin
    case (cap_q.addr[1:0])
      2'd0:    sel_byte = rd_word[31:24];
      2'd1:    sel_byte = rd_word[23:16];
      2'd2:    sel_byte = rd_word[15:8];
      default: sel_byte = rd_word[7:0];
    endcase
    sel_half = cap_q.addr[1] ? rd_word[15:0] : rd_word[31:16];
    case (cap_q.size)
      SZ_BYTE: fmt = cap_q.sext ? {{24{sel_byte[7]}}, sel_byte} : {24'b0, sel_byte};
      SZ_HALF: fmt = cap_q.sext ? {{16{sel_half[15]}}, sel_half} : {16'b0, sel_half};
      SZ_WORD: fmt = rd_word;
      default: fmt = '0;
    endcase
    if (err_q || cap_q.write) begin
      fmt = '0;
    end
  end

  // Keep the last response data visible outside RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (state == RESP) begin
      hold_q <= fmt;
    end
  end

  // Response outputs.
  always_comb begin
    resp_rdata = (state == RESP) ? fmt : hold_q;
    resp_err   = err_q;
  end

endmodule

// File: tb/tb_dmem_wait.sv
// Bench for dmem_wait: a WAIT_CYCLES=1 instance carries the functional
// scenarios through a scoreboard; a WAIT_CYCLES=0 instance checks spacing.
module tb_dmem_wait;
  import dmem_wait_pkg::*;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_ready0, req_write0, req_signed0;
  logic [1:0]  req_size0;
  logic [31:0] req_addr0, req_wdata0;
  logic        resp_valid0, resp_err0;
  logic [31:0] resp_rdata0;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb_q[$];
  logic [7:0]  mdl [0:255];

  dmem_wait #(.DEPTH_BYTES(256), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  dmem_wait #(.DEPTH_BYTES(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_size(req_size0), .req_signed(req_signed0), .req_addr(req_addr0),
    .req_wdata(req_wdata0), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
    .resp_err(resp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Reference behaviour: big-endian byte memory with fault rules.
  task automatic model_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] ed, output logic ee);
    int unsigned n;
    longint unsigned last;
    logic [31:0] v;
    logic [7:0] idx;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    last = {32'b0, a} + longint'(n) - 1;
    ee = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
         (sz == 2'b10 && a[1:0] != 2'b00) || (last >= 256);
    ed = '0;
    if (!ee) begin
      if (wr) begin
        for (int unsigned k = 0; k < n; k++) begin
          idx = a[7:0] + 8'(k);
          mdl[idx] = wd[8*(n-1-k) +: 8];
        end
      end else begin
        v = '0;
        for (int unsigned k = 0; k < n; k++) begin
          idx = a[7:0] + 8'(k);
          v = (v << 8) | {24'b0, mdl[idx]};
        end
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        ed = v;
      end
    end
  endtask

  // Scoreboard: every response on the main instance is matched in order.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: resp_valid with no outstanding request (rdata=%h err=%b)",
                 resp_rdata, resp_err);
      end else begin
        e = sb_q.pop_front();
        if ({resp_err, resp_rdata} !== e) begin
          errors++;
          $display("FAIL sb_resp: got err=%b rdata=%h, expected err=%b rdata=%h",
                   resp_err, resp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  // Drive one request, push its expected response, wait for completion.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er);
    logic [31:0] ed;
    logic ee;
    bit got;
    lat = -1; rd = 'x; er = 'x; got = 0;
    @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%b, expected 1", req_ready);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_req(wr, sz, sg, a, wd, ed, ee);
      sb_q.push_back({ee, ed});
      #1 req_valid = 1'b0;
      lat = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        lat++;
        if (resp_valid === 1'b1) begin
          got = 1; rd = resp_rdata; er = resp_err;
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL resp_timeout: resp_valid=%b, expected 1 within 20 cycles", resp_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    req_valid0 = 0; req_write0 = 0; req_size0 = 0; req_signed0 = 0; req_addr0 = 0; req_wdata0 = 0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", req_ready); end
    checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL release_ready0: got %b expected 1", req_ready0); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er;
    issue(1, SZ_WORD, 0, 32'h10, 32'h1122_3344, lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL store_resp: got %h/%b expected 0/0", rd, er); end
    issue(0, SZ_WORD, 0, 32'h10, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL load_word: got %h expected 11223344", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency: got %0d expected 2", lat); end
    issue(0, SZ_BYTE, 0, 32'h11, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000_0022) begin errors++; $display("FAIL load_byte: got %h expected 00000022", rd); end
    issue(0, SZ_HALF, 0, 32'h12, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000_3344) begin errors++; $display("FAIL load_half_hi: got %h expected 00003344", rd); end
  endtask

  task automatic test_subword();
    int lat; logic [31:0] rd; logic er;
    issue(1, SZ_BYTE, 0, 32'h20, 32'hAAAA_AA80, lat, rd, er);
    issue(1, SZ_BYTE, 0, 32'h21, 32'h5555_55F0, lat, rd, er);
    issue(0, SZ_HALF, 1, 32'h20, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFF_80F0) begin errors++; $display("FAIL half_signed: got %h expected ffff80f0", rd); end
    issue(0, SZ_HALF, 0, 32'h20, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000_80F0) begin errors++; $display("FAIL half_unsigned: got %h expected 000080f0", rd); end
    issue(0, SZ_BYTE, 1, 32'h21, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFFFF_FFF0) begin errors++; $display("FAIL byte_signed: got %h expected fffffff0", rd); end
    issue(1, SZ_HALF, 0, 32'h22, 32'h0000_7E01, lat, rd, er);
    issue(0, SZ_WORD, 1, 32'h20, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h80F0_7E01) begin errors++; $display("FAIL word_after_half: got %h expected 80f07e01", rd); end
  endtask

  task automatic test_bounds();
    int lat; logic [31:0] rd; logic er;
    issue(1, SZ_WORD, 0, 32'h13, 32'hCAFE_BABE, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_store: got err=%b rdata=%h expected 1/0", er, rd); end
    issue(0, SZ_WORD, 0, 32'h10, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h1122_3344 || er !== 1'b0) begin errors++; $display("FAIL unchanged_after_fault: got %h/%b expected 11223344/0", rd, er); end
    issue(1, SZ_WORD, 0, 32'hFC, 32'h0102_0304, lat, rd, er);
    issue(0, SZ_HALF, 0, 32'hFE, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000_0304 || er !== 1'b0) begin errors++; $display("FAIL half_at_top: got %h/%b expected 00000304/0", rd, er); end
    issue(0, SZ_WORD, 0, 32'hFC, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0102_0304 || er !== 1'b0) begin errors++; $display("FAIL word_at_top: got %h/%b expected 01020304/0", rd, er); end
    @(negedge clk);
    checks++; if (resp_rdata !== 32'h0102_0304) begin errors++; $display("FAIL rdata_hold: got %h expected 01020304", resp_rdata); end
    issue(0, SZ_WORD, 0, 32'h100, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL word_past_end: got err=%b rdata=%h expected 1/0", er, rd); end
    @(negedge clk);
    checks++; if (resp_err !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL err_hold: got err=%b valid=%b expected 1/0", resp_err, resp_valid); end
    issue(1, SZ_HALF, 0, 32'hFF, 32'h1234, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL half_odd: got err=%b expected 1", er); end
    issue(0, 2'b11, 0, 32'h10, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL illegal_size: got err=%b expected 1", er); end
    issue(0, SZ_WORD, 0, 32'hFFFF_FFFC, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL no_wrap: got err=%b expected 1", er); end
    issue(0, SZ_BYTE, 0, 32'hFF, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000_0004 || er !== 1'b0) begin errors++; $display("FAIL last_byte: got %h/%b expected 00000004/0", rd, er); end
  endtask

  task automatic test_back_to_back();
    int last; int acc;
    logic [31:0] ed; logic ee;
    last = -1; acc = 0;
    @(negedge clk);
    req_write = 0; req_size = SZ_WORD; req_signed = 0; req_addr = 32'h10; req_wdata = 0;
    req_valid = 1'b1;
    for (int cyc = 0; cyc <= 15; cyc++) begin
      if (cyc == 15) begin
        req_valid = 1'b0;
      end else if (req_ready === 1'b1) begin
        acc++;
        model_req(0, SZ_WORD, 0, 32'h10, 32'h0, ed, ee);
        sb_q.push_back({ee, ed});
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 3) begin errors++; $display("FAIL spacing_w1: got %0d expected 3", cyc - last); end
        end
        last = cyc;
      end
      @(negedge clk);
    end
    checks++; if (acc < 4) begin errors++; $display("FAIL accepts_w1: got %0d expected >= 4", acc); end
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL sb_drain: got %0d outstanding expected 0", sb_q.size()); end
  endtask

  task automatic test_back_to_back_w0();
    int last; int acc; bit prev;
    last = -1; acc = 0; prev = 0;
    @(negedge clk);
    req_write0 = 1; req_size0 = SZ_WORD; req_signed0 = 0; req_addr0 = 32'h0; req_wdata0 = 32'h1234_5678;
    req_valid0 = 1'b1;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      if (prev) begin
        checks++;
        if (resp_valid0 !== 1'b1) begin errors++; $display("FAIL w0_latency: resp_valid0=%b expected 1", resp_valid0); end
      end
      prev = 0;
      if (cyc == 12) begin
        req_valid0 = 1'b0;
      end else if (req_ready0 === 1'b1) begin
        acc++; prev = 1;
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 2) begin errors++; $display("FAIL spacing_w0: got %0d expected 2", cyc - last); end
        end
        last = cyc;
      end
      @(negedge clk);
    end
    checks++; if (acc < 5) begin errors++; $display("FAIL accepts_w0: got %0d expected >= 5", acc); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er;
    issue(1, SZ_WORD, 0, 32'h40, 32'h0, lat, rd, er);
    issue(0, SZ_WORD, 0, 32'h100, 32'h0, lat, rd, er);
    @(negedge clk);
    req_write = 1; req_size = SZ_WORD; req_signed = 0; req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wait_valid: got %b expected 0", resp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", req_ready); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b expected 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", resp_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_resp: got %b expected 0", resp_valid); end
    end
    issue(0, SZ_WORD, 0, 32'h40, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL abort_no_commit: got %h/%b expected 00000000/0", rd, er); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_subword();
    test_bounds();
    test_back_to_back();
    test_back_to_back_w0();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
